// File: rtl/wca_packer_pkg.sv
// ============================================================================
// Module      : wca_packer_pkg
// Description : Shared types and constants for the wca_sample_packer slice:
//               packer state encoding, sample-mode codes, default header sync
//               byte and the header word builder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wca_packer_pkg;

  // Packer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_e;

  // Sample packing modes, latched when the stream starts.
  localparam logic MODE_IQ16 = 1'b0;  // one 16-bit I/Q pair per word
  localparam logic MODE_IQ8  = 1'b1;  // two 8-bit I/Q pairs per word

  // Default sync byte placed in header word bits [31:24].
  localparam logic [7:0] HDR_SYNC_DEFAULT = 8'hA5;

  // Header word layout: {sync, overflow count, sequence number}.
  function automatic logic [31:0] make_hdr(input logic [7:0]  sync,
                                           input logic [7:0]  ovf,
                                           input logic [15:0] seq);
    return {sync, ovf, seq};
  endfunction

endpackage

`default_nettype wire

// File: rtl/wca_sat_counter8.sv
// ============================================================================
// Module      : wca_sat_counter8
// Description : 8-bit up counter that sticks at 8'hFF, with synchronous clear
//               (priority over increment) and asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wca_sat_counter8 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [7:0] o_count
);

  logic [7:0] r_count;

  // Count increments until all ones, then holds; clear wins over increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= 8'h00;
    end else if (i_clr) begin
      r_count <= 8'h00;
    end else if (i_inc && (r_count != 8'hFF)) begin
      r_count <= r_count + 8'h01;
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/wca_sample_packer.sv
// ============================================================================
// Module      : wca_sample_packer
// Description : Packs strobed 16-bit I/Q samples into 32-bit FIFO words with a
//               one-cycle write strobe. Mode 0 emits {I,Q} per sample; mode 1
//               emits {I1[15:8],Q1[15:8],I2[15:8],Q2[15:8]} per sample pair.
//               Words presented while the FIFO is full are dropped and counted
//               in a saturating overflow counter.
//               Build option WCA_PACKER_HEADER_EN adds a header word
//               {HDR_SYNC, overflow_count, seq} ahead of every FRAME_LEN
//               data words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wca_sample_packer
  import wca_packer_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 256,
  parameter logic [7:0]  HDR_SYNC  = HDR_SYNC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        mode,
  input  logic        strobe_in,
  input  logic [15:0] i_in,
  input  logic [15:0] q_in,
  input  logic        fifo_full,
  output logic [31:0] out,
  output logic        enable_out,
  output logic [7:0]  overflow_count
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic        r_mode;
  logic        r_half_vld;
  logic [15:0] r_half;
  logic [31:0] r_out;
  logic        r_wen;

  logic        w_start;       // leaving IDLE: latch mode, clear overflow count
  logic        w_store_half;  // first sample of a mode-1 pair
  logic        w_data_emit;   // a data word is presented this cycle
  logic        w_emit;
  logic        w_drop;
  logic [31:0] w_data_word;
  logic [7:0]  w_ovf_count;

`ifdef WCA_PACKER_HEADER_EN
  localparam logic [15:0] c_LAST_WORD = 16'(FRAME_LEN - 1);

  logic [15:0] r_word_cnt;
  logic [15:0] r_seq;
  logic        w_hdr_emit;
  logic        w_hdr_strobe_drop;
  logic        w_frame_end;
`else
  // Framing parameters only matter in header builds.
  logic        w_unused_cfg;
  assign w_unused_cfg = ^{HDR_SYNC, 16'(FRAME_LEN)};
`endif

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle emit/store decisions; enable low always wins.
  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_store_half = 1'b0;
    w_data_emit  = 1'b0;
`ifdef WCA_PACKER_HEADER_EN
    w_hdr_emit        = 1'b0;
    w_hdr_strobe_drop = 1'b0;
    w_frame_end       = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_start = 1'b1;
`ifdef WCA_PACKER_HEADER_EN
          w_state_nxt = HDR;
`else
          w_state_nxt = DATA;
`endif
        end
      end
`ifdef WCA_PACKER_HEADER_EN
      HDR: begin
        if (!enable) begin
          w_state_nxt = IDLE;
        end else begin
          // A sample arriving in the header slot has nowhere to go.
          w_hdr_emit        = 1'b1;
          w_hdr_strobe_drop = strobe_in;
          w_state_nxt       = DATA;
        end
      end
`endif
      DATA: begin
        if (!enable) begin
          w_state_nxt = IDLE;
        end else if (strobe_in) begin
          if ((r_mode == MODE_IQ8) && !r_half_vld) begin
            w_store_half = 1'b1;
          end else begin
            w_data_emit = 1'b1;
`ifdef WCA_PACKER_HEADER_EN
            // Dropped words count toward the frame so its length is fixed.
            if (r_word_cnt == c_LAST_WORD) begin
              w_frame_end = 1'b1;
              w_state_nxt = HDR;
            end
`endif
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_data_word = (r_mode == MODE_IQ8) ? {r_half, i_in[15:8], q_in[15:8]}
                                            : {i_in, q_in};

`ifdef WCA_PACKER_HEADER_EN
  assign w_emit = w_data_emit | w_hdr_emit;
  assign w_drop = (w_emit & fifo_full) | w_hdr_strobe_drop;
`else
  assign w_emit = w_data_emit;
  assign w_drop = w_emit & fifo_full;
`endif

  // Stream mode is captured once per stream start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mode <= MODE_IQ16;
    end else if (w_start) begin
      r_mode <= mode;
    end
  end

  // Mode-1 upper half-word; discarded whenever the stream stops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_half_vld <= 1'b0;
      r_half     <= 16'h0000;
    end else if (w_state_nxt == IDLE) begin
      r_half_vld <= 1'b0;
    end else if (w_store_half) begin
      r_half_vld <= 1'b1;
      r_half     <= {i_in[15:8], q_in[15:8]};
    end else if (w_data_emit) begin
      r_half_vld <= 1'b0;
    end
  end

  // Output word and write strobe; the word updates even when the FIFO is full.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out <= 32'h0000_0000;
      r_wen <= 1'b0;
    end else begin
      r_wen <= w_emit & ~fifo_full;
      if (w_emit) begin
`ifdef WCA_PACKER_HEADER_EN
        r_out <= w_hdr_emit ? make_hdr(HDR_SYNC, w_ovf_count, r_seq) : w_data_word;
`else
        r_out <= w_data_word;
`endif
      end
    end
  end

`ifdef WCA_PACKER_HEADER_EN
  // Frame position restarts with each stream; sequence only resets with reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_word_cnt <= 16'h0000;
      r_seq      <= 16'h0000;
    end else begin
      if (w_start || w_frame_end) begin
        r_word_cnt <= 16'h0000;
      end else if (w_data_emit) begin
        r_word_cnt <= r_word_cnt + 16'h0001;
      end
      if (w_hdr_emit) begin
        r_seq <= r_seq + 16'h0001;
      end
    end
  end
`endif

  wca_sat_counter8 u_ovf_cnt (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_clr   (w_start),
    .i_inc   (w_drop),
    .o_count (w_ovf_count)
  );

  assign out            = r_out;
  assign enable_out     = r_wen;
  assign overflow_count = w_ovf_count;

endmodule

`default_nettype wire
